// File: rtl/gpc223_4_arbiter.sv
// rtl/gpc223_4_arbiter.sv - round-robin issue stage sharing one (2,2,3;4) counter
// Requesters hand over operand triples; the granted one is summed and registered with its index.

module gpc223_4 (
  input  logic [2:0] src0,
  input  logic [1:0] src1,
  input  logic [1:0] src2,
  output logic [3:0] dst
);

  always_comb begin
    dst = {3'b000, src0[0]} + {3'b000, src0[1]} + {3'b000, src0[2]}
        + {2'b00, src1[0], 1'b0} + {2'b00, src1[1], 1'b0}
        + {1'b0, src2[0], 2'b00} + {1'b0, src2[1], 2'b00};
  end

endmodule

module gpc223_4_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [3*NREQ-1:0] req_src0,
  input  logic [2*NREQ-1:0] req_src1,
  input  logic [2*NREQ-1:0] req_src2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_dst,
  output logic [ID_W-1:0]   out_id
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            out_valid_q, out_valid_d;
  logic [3:0]      out_dst_q, out_dst_d;
  logic [ID_W-1:0] out_id_q, out_id_d;

  logic            free;
  logic            gnt_found;
  int              gnt_i;
  int              cand;
  logic            xfer;
  logic [2:0]      g_src0;
  logic [1:0]      g_src1;
  logic [1:0]      g_src2;
  logic [3:0]      g_sum;

  assign free = !out_valid_q || out_ready;

  // Cyclic search starting at ptr; the first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_i     = 0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_i     = cand;
      end
    end
  end

  assign xfer      = gnt_found && free;
  assign req_ready = xfer ? (NREQ'(1) << gnt_i) : '0;

  assign g_src0 = req_src0[gnt_i*3 +: 3];
  assign g_src1 = req_src1[gnt_i*2 +: 2];
  assign g_src2 = req_src2[gnt_i*2 +: 2];

  gpc223_4 u_gpc (
    .src0 (g_src0),
    .src1 (g_src1),
    .src2 (g_src2),
    .dst  (g_sum)
  );

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_dst_d   = out_dst_q;
    out_id_d    = out_id_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_dst_d   = g_sum;
      out_id_d    = ID_W'(gnt_i);
      ptr_d       = (gnt_i == NREQ - 1) ? '0 : ID_W'(gnt_i + 1);
    end else if (free) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_dst_q   <= 4'h0;
      out_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_dst_q   <= out_dst_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_dst   = out_dst_q;
  assign out_id    = out_id_q;

endmodule

// File: doc/gpc223_4_arbiter.md
# gpc223_4_arbiter

Round-robin arbiter and issue stage that shares one `gpc223_4` generalized parallel counter among `NREQ` independent requesters. It takes 7-bit operand triples over per-requester valid/ready handshakes and grants one requester per cycle. The granted operands go through the internal `gpc223_4` instance, and the registered 4-bit sum comes out tagged with the requester index. The block sits between compressor-tree front ends that each need occasional (2,2,3;4) reductions and the single counter resource allotted to them.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..8.
- `ID_W`, default 2: width of `out_id`; must satisfy 2^ID_W >= NREQ.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  NREQ: bit i set means requester i presents operands.
- `req_ready`  out  NREQ: bit i set means requester i's operands are accepted this cycle; at most one bit is set.
- `req_src0`  in  3*NREQ: weight-1 bits; bits [3i+2:3i] belong to requester i.
- `req_src1`  in  2*NREQ: weight-2 bits; bits [2i+1:2i] belong to requester i.
- `req_src2`  in  2*NREQ: weight-4 bits; bits [2i+1:2i] belong to requester i.
- `out_valid`  out  1: result register holds a valid result.
- `out_ready`  in  1: consumer accepts the result.
- `out_dst`  out  4: result, equal to src0[0]+src0[1]+src0[2] + 2*(src1[0]+src1[1]) + 4*(src2[0]+src2[1]).
- `out_id`  out  ID_W: index of the requester that produced `out_dst`.

## Operation
- State:
  - round-robin pointer `ptr` (ID_W bits, range 0..NREQ-1);
  - output register (`out_valid`, `out_dst`, `out_id`).
- Stage free: `free = !out_valid || out_ready`.
- Grant:
  - the grant is the first requester with `req_valid` set, searched cyclically from `ptr` upward (`ptr`, `ptr`+1, …, NREQ-1, 0, …, `ptr`-1);
  - there is no grant if `req_valid` is all zero.
- `req_ready[g] = free` for the granted index g; all other bits are 0. `req_ready` depends combinationally on `req_valid` and `ptr`. Requesters must not make `req_valid` depend on `req_ready`.
- Transfer: happens when `req_valid[g] && req_ready[g]`. On a transfer:
  - the granted operand slice drives the `gpc223_4` instance;
  - `out_dst` loads the instance output, `out_id` loads g, `out_valid` is set to 1;
  - `ptr` loads (g+1) mod NREQ, wrapping from NREQ-1 to 0.
- No transfer while `free`: `out_valid` is cleared to 0, and `ptr`, `out_dst` and `out_id` hold.
- Not free (`out_valid && !out_ready`): all outputs hold their values and `ptr` holds.
- Fairness: a requester that keeps `req_valid` asserted is served within NREQ transfers.
- Requesters hold their operands stable while `req_valid` is set and they are not yet accepted.
- Width: the maximum sum is 3+4+8 = 15, so it fits 4 bits with no overflow and no saturation logic.

## Timing
- Reset values:
  - `out_valid` = 0, `out_dst` = 0, `out_id` = 0, `ptr` = 0;
  - `req_ready` = 0 whenever `req_valid` = 0.
- Reset asserted mid-operation: any held result is dropped immediately (asynchronously) and `ptr` returns to 0.
- Latency: operands accepted at edge N appear on `out_*` after edge N with `out_valid` = 1, i.e. one cycle.
- Throughput: one result per cycle while `out_ready` = 1.
- Simultaneous drain and accept: if `out_valid && out_ready` and a request is granted in the same cycle, the old result leaves and the new one loads on that edge, with no bubble.
- Single valid requester: it is granted every cycle regardless of `ptr`.

## Test plan
- Reset check: pulse `rst` with `req_valid`=0 and `out_ready`=1 → `out_valid`=0, `out_dst`=0, `out_id`=0, `req_ready`=0; releasing reset changes nothing.
- Single request: only requester 2 valid with src0=3'b111, src1=2'b11, src2=2'b11 → `req_ready`=4'b0100 this cycle; next cycle `out_valid`=1, `out_dst`=4'hf, `out_id`=2.
- Rotation: all 4 requesters held valid, `out_ready`=1 → over 5 consecutive cycles `out_id` = 0,1,2,3,0, and each `out_dst` matches the weighted sum of that requester's operands.
- Backpressure:
  - requester 1 sends src0=3'b101, src1=2'b01, src2=2'b00 → `out_dst`=4, `out_id`=1;
  - hold `out_ready`=0 for 3 cycles with requesters 0 and 3 valid → outputs stay stable and `req_ready`=0 throughout;
  - raise `out_ready` → requester 3 is accepted that same cycle, with `ptr` previously at 2.
- Exhaustive datapath: requester 0 alone sweeps all 128 patterns of {src2,src1,src0} → every `out_dst` equals the weighted sum (0..15) and every `out_id`=0.
- Reset mid-stall: `out_valid`=1 held with `out_ready`=0, then assert `rst` → `out_valid` drops with no clock edge, and afterwards grant search restarts from requester 0.
